// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between predictor/execute and the branch resolve queue.
// master = predictor/execute side, slave = the queue itself.
interface branch_resolve_queue_if #(
  parameter int PC_W = 5
);
  logic            pred_valid;
  logic            pred_ready;
  logic [PC_W-1:0] pred_pc;
  logic [PC_W-1:0] pred_target;
  logic            pred_taken;

  logic            res_valid;
  logic            res_ready;
  logic [PC_W-1:0] res_target;

  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic [PC_W-1:0] upd_target;
  logic            upd_taken;
  logic            upd_mispredict;

  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output pred_valid, pred_pc, pred_target, pred_taken, res_valid, res_target,
    input  pred_ready, res_ready,
    input  upd_valid, upd_pc, upd_target, upd_taken, upd_mispredict,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  pred_valid, pred_pc, pred_target, pred_taken, res_valid, res_target,
    output pred_ready, res_ready,
    output upd_valid, upd_pc, upd_target, upd_taken, upd_mispredict,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of branch predictions resolved against execute's effective address.
// Define BRQ_STATS_EN to build the saturating accuracy counters.
module branch_resolve_queue #(
  parameter int PC_W  = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  branch_resolve_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         correct_cnt,
  output logic [CNT_W-1:0]         total_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic            taken;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head_ptr;
  logic [AW-1:0]   tail_ptr;
  logic [0:0]      state;

  entry_t          head_e;
  logic [PC_W-1:0] seq_pc;
  logic            push;
  logic            pop;
  logic            mispredict;
  logic            actual_taken;
  logic            flush;
  logic            push_keep;

  assign bus.pred_ready = (state == ST_RUN) && (occupancy != OW'(DEPTH));
  assign bus.res_ready  = (state == ST_RUN) && (occupancy != '0);

  assign push   = bus.pred_valid && bus.pred_ready;
  assign pop    = bus.res_valid && bus.res_ready;
  assign head_e = mem[head_ptr];

  // Fall-through PC wraps within the PC width, like the fetch unit's adder.
  assign seq_pc       = head_e.pc + PC_W'(4);
  assign actual_taken = (bus.res_target != seq_pc);
  assign mispredict   = (bus.res_target != head_e.target);
  assign flush        = pop && mispredict;
  assign push_keep    = push && !flush;

  // NOTE: entry storage has no reset; an entry is only read after occupancy says it was written.
  always_ff @(posedge clk) begin
    if (push_keep) mem[tail_ptr] <= '{pc: bus.pred_pc, target: bus.pred_target, taken: bus.pred_taken};
  end

  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_RUN;
      head_ptr           <= '0;
      tail_ptr           <= '0;
      occupancy          <= '0;
      bus.upd_valid      <= 1'b0;
      bus.upd_pc         <= '0;
      bus.upd_target     <= '0;
      bus.upd_taken      <= 1'b0;
      bus.upd_mispredict <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.upd_valid      <= pop;
      bus.redirect_valid <= flush;
      if (pop) begin
        bus.upd_pc         <= head_e.pc;
        bus.upd_target     <= bus.res_target;
        bus.upd_taken      <= actual_taken;
        bus.upd_mispredict <= mispredict;
      end
      if (flush) begin
        // Drop every younger prediction and give fetch one quiet cycle.
        bus.redirect_pc <= bus.res_target;
        head_ptr        <= tail_ptr;
        occupancy       <= '0;
        state           <= ST_RECOVER;
      end else begin
        if (push_keep) tail_ptr <= tail_ptr + AW'(1);
        if (pop)       head_ptr <= head_ptr + AW'(1);
        occupancy <= occupancy + OW'(push_keep) - OW'(pop);
        state     <= ST_RUN;
      end
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      correct_cnt <= '0;
      total_cnt   <= '0;
    end else if (pop) begin
      if (total_cnt != '1) total_cnt <= total_cnt + CNT_W'(1);
      if (!mispredict && correct_cnt != '1) correct_cnt <= correct_cnt + CNT_W'(1);
    end
  end
`else
  assign correct_cnt = '0;
  assign total_cnt   = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomised plus directed bench for branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int PC_W    = 5;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int OW      = $clog2(DEPTH) + 1;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BRQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.PC_W(PC_W)) bus ();
  logic [OW-1:0]    occupancy;
  logic [CNT_W-1:0] correct_cnt;
  logic [CNT_W-1:0] total_cnt;

  branch_resolve_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .occupancy   (occupancy),
    .correct_cnt (correct_cnt),
    .total_cnt   (total_cnt)
  );

  typedef struct {
    int pc;
    int target;
    bit taken;
  } ent_t;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t q[$];
  bit   m_recover;
  int   m_correct, m_total;
  bit   e_upd_valid, e_upd_taken, e_upd_mis, e_redir_valid;
  int   e_upd_pc, e_upd_target, e_redir_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_recover     = 1'b0;
    m_correct     = 0;
    m_total       = 0;
    e_upd_valid   = 1'b0;
    e_upd_pc      = 0;
    e_upd_target  = 0;
    e_upd_taken   = 1'b0;
    e_upd_mis     = 1'b0;
    e_redir_valid = 1'b0;
    e_redir_pc    = 0;
  endtask

  task automatic check_outputs();
    check("upd_valid",      bus.upd_valid,      e_upd_valid);
    check("upd_pc",         bus.upd_pc,         e_upd_pc);
    check("upd_target",     bus.upd_target,     e_upd_target);
    check("upd_taken",      bus.upd_taken,      e_upd_taken);
    check("upd_mispredict", bus.upd_mispredict, e_upd_mis);
    check("redirect_valid", bus.redirect_valid, e_redir_valid);
    check("redirect_pc",    bus.redirect_pc,    e_redir_pc);
    check("occupancy",      occupancy,          q.size());
    check("correct_cnt",    correct_cnt,        STATS ? m_correct : 0);
    check("total_cnt",      total_cnt,          STATS ? m_total : 0);
  endtask

  // One clock: offer inputs, check readiness, clock, advance model, check outputs.
  task automatic cycle(input bit pv, input int pc, input int tg, input bit tk,
                       input bit rv, input int rt);
    bit   acc_push, acc_pop, mis;
    ent_t h;
    bus.pred_valid  = pv;
    bus.pred_pc     = PC_W'(pc);
    bus.pred_target = PC_W'(tg);
    bus.pred_taken  = tk;
    bus.res_valid   = rv;
    bus.res_target  = PC_W'(rt);
    #1;
    check("pred_ready", bus.pred_ready, !m_recover && q.size() < DEPTH);
    check("res_ready",  bus.res_ready,  !m_recover && q.size() > 0);
    acc_push = pv && !m_recover && q.size() < DEPTH;
    acc_pop  = rv && !m_recover && q.size() > 0;
    @(posedge clk);
    e_upd_valid   = acc_pop;
    e_redir_valid = 1'b0;
    mis           = 1'b0;
    if (acc_pop) begin
      h            = q.pop_front();
      mis          = (rt % PC_MOD) != h.target;
      e_upd_pc     = h.pc;
      e_upd_target = rt % PC_MOD;
      e_upd_taken  = (rt % PC_MOD) != ((h.pc + 4) % PC_MOD);
      e_upd_mis    = mis;
      if (m_total < CNT_MAX) m_total++;
      if (!mis && m_correct < CNT_MAX) m_correct++;
      if (mis) begin
        q.delete();
        e_redir_valid = 1'b1;
        e_redir_pc    = rt % PC_MOD;
      end
    end
    if (acc_push && !mis) q.push_back('{pc: pc % PC_MOD, target: tg % PC_MOD, taken: tk});
    m_recover = acc_pop && mis;
    #1;
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic resolve_head_ok();
    cycle(1'b0, 0, 0, 1'b0, 1'b1, q[0].target);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check("rst_pred_ready", bus.pred_ready, 1'b1);
    check("rst_res_ready",  bus.res_ready,  1'b0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.pred_valid  = 1'b0;
    bus.pred_pc     = '0;
    bus.pred_target = '0;
    bus.pred_taken  = 1'b0;
    bus.res_valid   = 1'b0;
    bus.res_target  = '0;
    rst_n = 1'b0;
    model_reset();
    #3;
    check_outputs();
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle();

    // Correct not-taken resolution.
    cycle(1'b1, 4, 8, 1'b0, 1'b0, 0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 8);
    check("nt_upd_valid", bus.upd_valid, 1'b1);
    check("nt_upd_taken", bus.upd_taken, 1'b0);
    check("nt_upd_mis",   bus.upd_mispredict, 1'b0);
    check("nt_redirect",  bus.redirect_valid, 1'b0);
    check("nt_total",     total_cnt, STATS ? 1 : 0);
    idle();

    // Mispredict flushes the younger entry and squashes the concurrent push.
    cycle(1'b1, 9, 13, 1'b0, 1'b0, 0);
    cycle(1'b1, 13, 17, 1'b0, 1'b0, 0);
    cycle(1'b1, 20, 24, 1'b1, 1'b1, 1);
    check("mp_upd_mis",     bus.upd_mispredict, 1'b1);
    check("mp_upd_taken",   bus.upd_taken, 1'b1);
    check("mp_redirect",    bus.redirect_valid, 1'b1);
    check("mp_redirect_pc", bus.redirect_pc, 1);
    check("mp_occupancy",   occupancy, 0);
    check("mp_recover_rdy", bus.pred_ready, 1'b0);
    cycle(1'b1, 7, 11, 1'b0, 1'b1, 11);
    check("mp_after_occ",   occupancy, 0);
    check("mp_redir_pulse", bus.redirect_valid, 1'b0);
    idle();

    // Fall-through address wraps modulo 2^PC_W.
    cycle(1'b1, 30, 2, 1'b0, 1'b0, 0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 2);
    check("wrap_taken", bus.upd_taken, 1'b0);
    check("wrap_mis",   bus.upd_mispredict, 1'b0);

    // Fill, refuse the fifth push, no bypass on a full pop, then drain.
    for (int i = 0; i < 5; i++) cycle(1'b1, i, i + 4, 1'b0, 1'b0, 0);
    check("full_occ", occupancy, 4);
    cycle(1'b1, 17, 21, 1'b0, 1'b1, q[0].target);
    check("full_nobypass_occ", occupancy, 3);
    while (q.size() > 0) resolve_head_ok();
    cycle(1'b0, 0, 0, 1'b0, 1'b1, 5);
    check("empty_no_upd", bus.upd_valid, 1'b0);

    // Reset in the middle of operation.
    for (int i = 0; i < 3; i++) cycle(1'b1, 3 * i, 3 * i + 6, 1'b1, 1'b0, 0);
    reset_pulse();
    idle();
    check("post_rst_upd", bus.upd_valid, 1'b0);
    idle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int pc, tg, rt;
      pc = $urandom_range(0, PC_MOD - 1);
      tg = ($urandom_range(0, 1) != 0) ? pc + 4 : $urandom_range(0, PC_MOD - 1);
      rt = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[0].target
                                                        : $urandom_range(0, PC_MOD - 1);
      cycle(1'($urandom_range(0, 1)), pc, tg, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rt);
    end

    // Counter saturation.
    reset_pulse();
    for (int i = 0; i < 260; i++) begin
      cycle(1'b1, i, i + 7, 1'b1, 1'b0, 0);
      resolve_head_ok();
    end
    check("sat_correct", correct_cnt, STATS ? CNT_MAX : 0);
    check("sat_total",   total_cnt,   STATS ? CNT_MAX : 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
